// File: rtl/timer_pkg.sv
// +-----------------------------------------------------------------------+
// | timer_pkg : shared state/mode encodings and config reset defaults     |
// | Rev 1.0   : initial release                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   localparam logic [7:0] CFG_PERIOD_RST   = 8'hFF;
   localparam logic [3:0] CFG_PRESCALE_RST = 4'd0;
   localparam logic       CFG_MODE_RST     = MODE_ONESHOT;

endpackage

`default_nettype wire

// File: rtl/timer_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | timer_ctrl_if : config/strobe/status bundle for timer_ctrl            |
// | Optional irq/irq_clr signals under macro TIMER_CTRL_IRQ_EN            |
// | Rev 1.0       : initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

interface timer_ctrl_if #(
   parameter int CNT_W = 8,
   parameter int PRE_W = 4
);
   logic             cfg_we;
   logic [CNT_W-1:0] cfg_period;
   logic [PRE_W-1:0] cfg_prescale;
   logic             cfg_mode;
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             done;
   logic             tc_pulse;
`ifdef TIMER_CTRL_IRQ_EN
   logic             irq_clr;
   logic             irq;
`endif

   modport master (
      output cfg_we, cfg_period, cfg_prescale, cfg_mode, start, stop,
`ifdef TIMER_CTRL_IRQ_EN
      output irq_clr,
      input  irq,
`endif
      input  count, busy, done, tc_pulse
   );

   modport slave (
      input  cfg_we, cfg_period, cfg_prescale, cfg_mode, start, stop,
`ifdef TIMER_CTRL_IRQ_EN
      input  irq_clr,
      output irq,
`endif
      output count, busy, done, tc_pulse
   );
endinterface

`default_nettype wire

// File: rtl/timer_cnt_core.sv
// +-----------------------------------------------------------------------+
// | timer_cnt_core : up-counter with sync clear, increment enable and     |
// |                  terminal-count equality compare                      |
// | Rev 1.0        : initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module timer_cnt_core #(
   parameter int CNT_W = 8
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_clr,
   input  wire logic             i_inc,
   input  wire logic [CNT_W-1:0] i_period,
   output logic      [CNT_W-1:0] o_count,
   output logic                  o_at_tc
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;
   assign o_at_tc = (r_count == i_period);

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// +-----------------------------------------------------------------------+
// | timer_ctrl : programmable timer sequencer (period, prescale, modes)   |
// | Optional irq latch under macro TIMER_CTRL_IRQ_EN                      |
// | Rev 1.0    : initial release                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module timer_ctrl
   import timer_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int PRE_W = 4
) (
   input  wire logic   clk,
   input  wire logic   reset,
   timer_ctrl_if.slave bus
);

   state_t           r_state;
   logic [CNT_W-1:0] r_period;
   logic [PRE_W-1:0] r_prescale;
   logic [PRE_W-1:0] r_pre;
   logic             r_mode;
   logic             r_busy;
   logic             r_done;
   logic             r_tc;

   logic [CNT_W-1:0] w_count;
   logic             w_at_tc;
   logic             w_tick;
   logic             w_clr;
   logic             w_inc;

   assign w_tick = (r_state == RUN) && (r_pre == r_prescale);
   // stop dominates everything, including a tick landing on terminal count
   assign w_clr  = bus.stop || (r_state == IDLE) || (r_state == LOAD) ||
                   (w_tick && w_at_tc && (r_mode == MODE_PERIODIC));
   assign w_inc  = w_tick && !w_at_tc;

   timer_cnt_core #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (w_clr),
      .i_inc    (w_inc),
      .i_period (r_period),
      .o_count  (w_count),
      .o_at_tc  (w_at_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_period   <= CNT_W'(CFG_PERIOD_RST);
         r_prescale <= PRE_W'(CFG_PRESCALE_RST);
         r_mode     <= CFG_MODE_RST;
         r_pre      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_tc       <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (bus.stop) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               IDLE, DONE: begin
                  if (bus.cfg_we) begin
                     r_period   <= bus.cfg_period;
                     r_prescale <= bus.cfg_prescale;
                     r_mode     <= bus.cfg_mode;
                  end
                  if (bus.start) begin
                     r_state <= LOAD;
                     r_busy  <= 1'b1;
                  end
               end
               LOAD: begin
                  r_pre   <= '0;
                  r_done  <= 1'b0;
                  r_state <= RUN;
               end
               RUN: begin
                  if (w_tick) begin
                     r_pre <= '0;
                     if (w_at_tc) begin
                        r_tc <= 1'b1;
                        if (r_mode == MODE_ONESHOT) begin
                           r_done  <= 1'b1;
                           r_busy  <= 1'b0;
                           r_state <= DONE;
                        end
                     end
                  end else begin
                     r_pre <= r_pre + PRE_W'(1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.count    = w_count;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.tc_pulse = r_tc;

`ifdef TIMER_CTRL_IRQ_EN
   logic r_irq;

   // set has priority over a coincident clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else if (r_tc) begin
         r_irq <= 1'b1;
      end else if (bus.irq_clr) begin
         r_irq <= 1'b0;
      end
   end

   assign bus.irq = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_timer_ctrl : directed self-checking bench for timer_ctrl           |
// | Rev 1.0       : initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_timer_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   n_tc;

   timer_ctrl_if #(.CNT_W(8), .PRE_W(4)) bus ();

   timer_ctrl #(.CNT_W(8), .PRE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [7:0] p, input logic [3:0] ps, input logic m);
      bus.cfg_period   = p;
      bus.cfg_prescale = ps;
      bus.cfg_mode     = m;
      bus.cfg_we       = 1'b1;
      cyc(1);
      bus.cfg_we       = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      cyc(1);
      bus.stop = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      bus.cfg_we = 1'b0;
      bus.cfg_period = 8'd0;
      bus.cfg_prescale = 4'd0;
      bus.cfg_mode = 1'b0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
`ifdef TIMER_CTRL_IRQ_EN
      bus.irq_clr = 1'b0;
`endif
      cyc(3);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_tc", 32'(bus.tc_pulse), 32'd0);
`ifdef TIMER_CTRL_IRQ_EN
      chk("rst_irq", 32'(bus.irq), 32'd0);
`endif
      reset = 1'b0;
      cyc(1);

      // periodic, period 3, prescale 0
      cfg(8'd3, 4'd0, 1'b1);
      pulse_start();
      chk("p3_load_busy", 32'(bus.busy), 32'd1);
      cyc(1);
      chk("p3_run_cnt0", 32'(bus.count), 32'd0);
      cyc(1);
      chk("p3_cnt1", 32'(bus.count), 32'd1);
      chk("p3_tc_lo", 32'(bus.tc_pulse), 32'd0);
      cyc(1);
      chk("p3_cnt2", 32'(bus.count), 32'd2);
      cyc(1);
      chk("p3_cnt3", 32'(bus.count), 32'd3);
      cyc(1);
      chk("p3_wrap_cnt", 32'(bus.count), 32'd0);
      chk("p3_wrap_tc", 32'(bus.tc_pulse), 32'd1);
      cyc(1);
      chk("p3_after_cnt", 32'(bus.count), 32'd1);
      chk("p3_after_tc", 32'(bus.tc_pulse), 32'd0);
      chk("p3_done", 32'(bus.done), 32'd0);

      // config write while busy must be ignored
      cfg(8'd9, 4'd2, 1'b0);
      chk("busy_cfg_cnt2", 32'(bus.count), 32'd2);
      cyc(1);
      chk("busy_cfg_cnt3", 32'(bus.count), 32'd3);
      cyc(1);
      chk("busy_cfg_wrap", 32'(bus.count), 32'd0);
      chk("busy_cfg_tc", 32'(bus.tc_pulse), 32'd1);

      // stop and start together: stop wins
      cyc(1);
      bus.start = 1'b1;
      bus.stop = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      bus.stop = 1'b0;
      chk("ss_busy", 32'(bus.busy), 32'd0);
      chk("ss_count", 32'(bus.count), 32'd0);
      chk("ss_tc", 32'(bus.tc_pulse), 32'd0);
      cyc(2);
      chk("ss_idle_busy", 32'(bus.busy), 32'd0);
      chk("ss_idle_cnt", 32'(bus.count), 32'd0);

      // reset during RUN with count 5
      cfg(8'd10, 4'd0, 1'b1);
      pulse_start();
      cyc(1);
      cyc(5);
      chk("mid_cnt5", 32'(bus.count), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count", 32'(bus.count), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_tc", 32'(bus.tc_pulse), 32'd0);
      cyc(2);
      reset = 1'b0;
      cyc(3);
      chk("post_rst_cnt", 32'(bus.count), 32'd0);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_tc", 32'(bus.tc_pulse), 32'd0);

      // reset defaults: one-shot, period FF, prescale 0
      pulse_start();
      cyc(1);
      cyc(255);
      chk("def_cntff", 32'(bus.count), 32'hFF);
      chk("def_tc_lo", 32'(bus.tc_pulse), 32'd0);
      cyc(1);
      chk("def_os_tc", 32'(bus.tc_pulse), 32'd1);
      chk("def_os_done", 32'(bus.done), 32'd1);
      chk("def_os_busy", 32'(bus.busy), 32'd0);
      chk("def_os_hold", 32'(bus.count), 32'hFF);
      pulse_start();
      chk("restart_busy", 32'(bus.busy), 32'd1);
      cyc(1);
      chk("restart_done", 32'(bus.done), 32'd0);
      chk("restart_cnt", 32'(bus.count), 32'd0);
      pulse_stop();

      // periodic, period FF: wrap FF->00 and one tc per 256 ticks
      cfg(8'hFF, 4'd0, 1'b1);
      pulse_start();
      cyc(1);
      cyc(255);
      chk("ff_cntff", 32'(bus.count), 32'hFF);
      cyc(1);
      chk("ff_wrap_cnt", 32'(bus.count), 32'd0);
      chk("ff_wrap_tc", 32'(bus.tc_pulse), 32'd1);
      n_tc = 0;
      for (int i = 0; i < 256; i++) begin
         cyc(1);
         if (bus.tc_pulse === 1'b1) n_tc++;
      end
      chk("ff_tc_per_256", 32'(n_tc), 32'd1);
      pulse_stop();

      // one-shot, period 2, prescale 1
      cfg(8'd2, 4'd1, 1'b0);
      pulse_start();
      cyc(1);
      chk("os_e1_cnt", 32'(bus.count), 32'd0);
      cyc(1);
      chk("os_e2_cnt", 32'(bus.count), 32'd0);
      cyc(1);
      chk("os_e3_cnt", 32'(bus.count), 32'd1);
      cyc(2);
      chk("os_e5_cnt", 32'(bus.count), 32'd2);
      chk("os_e5_tc", 32'(bus.tc_pulse), 32'd0);
      cyc(1);
      chk("os_e6_tc", 32'(bus.tc_pulse), 32'd0);
      cyc(1);
      chk("os_e7_tc", 32'(bus.tc_pulse), 32'd1);
      chk("os_e7_done", 32'(bus.done), 32'd1);
      chk("os_e7_busy", 32'(bus.busy), 32'd0);
      chk("os_e7_cnt", 32'(bus.count), 32'd2);
      cyc(1);
      chk("os_hold_tc", 32'(bus.tc_pulse), 32'd0);
      chk("os_hold_cnt", 32'(bus.count), 32'd2);
      chk("os_hold_done", 32'(bus.done), 32'd1);
      pulse_stop();
      chk("os_stop_done", 32'(bus.done), 32'd0);

      // period 0, prescale 0, periodic: continuous tc
      cfg(8'd0, 4'd0, 1'b1);
      pulse_start();
      cyc(1);
      chk("p0_run_tc", 32'(bus.tc_pulse), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("p0_tc_cont", 32'(bus.tc_pulse), 32'd1);
         chk("p0_cnt", 32'(bus.count), 32'd0);
      end
`ifdef TIMER_CTRL_IRQ_EN
      chk("irq_set", 32'(bus.irq), 32'd1);
      bus.irq_clr = 1'b1;
      cyc(1);
      chk("irq_set_wins", 32'(bus.irq), 32'd1);
      bus.irq_clr = 1'b0;
`endif
      pulse_stop();
      chk("p0_stop_tc", 32'(bus.tc_pulse), 32'd0);
`ifdef TIMER_CTRL_IRQ_EN
      bus.irq_clr = 1'b1;
      cyc(1);
      bus.irq_clr = 1'b0;
      chk("irq_clr", 32'(bus.irq), 32'd0);
`endif
      cyc(1);
      chk("end_busy", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control and sequencing block for the team's 8-bit up-counter datapath. Turns it into a programmable timer: loadable period, prescaler, one-shot/periodic modes, start/stop control, terminal-count signalling.
- Sits between a simple register-write interface (cfg_*/start/stop strobes) and the counter. Other blocks use it as a timebase / event generator.

Parameters:
- CNT_W, 8, counter and period width in bits.
- PRE_W, 4, prescaler width; tick divides clk by (cfg_prescale+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_we  input  1  config write strobe; loads cfg_period, cfg_prescale, cfg_mode.
- cfg_period  input  CNT_W  terminal count value (count runs 0..period).
- cfg_prescale  input  PRE_W  prescale divisor minus one.
- cfg_mode  input  1  0 = one-shot, 1 = periodic.
- start  input  1  single-cycle start strobe.
- stop  input  1  single-cycle stop/abort strobe.
- count  output  CNT_W  current counter value.
- busy  output  1  high in LOAD or RUN.
- done  output  1  sticky one-shot completion flag.
- tc_pulse  output  1  one-cycle terminal-count pulse.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - reset is asynchronous and active-high; asserting it forces every register to its reset value immediately.
- Reset values:
  - Outputs: count=0, busy=0, done=0, tc_pulse=0, state=IDLE.
  - Config registers: period=8'hFF, prescale=0, mode=0.
  - Prescaler counter: 0.
- Config writes:
  - cfg_we takes effect only in IDLE or DONE.
  - cfg_we is ignored while busy=1; no partial update.
- States:
  - IDLE: count=0. start goes to LOAD.
  - LOAD: one cycle. count<=0, prescaler<=0, done<=0. Then RUN.
  - RUN: prescaler increments each cycle. When it equals the prescale value it wraps to 0 and a tick occurs. On each tick:
    - If count != period: count<=count+1.
    - If count == period, periodic mode: count<=0, tc_pulse<=1, stay in RUN.
    - If count == period, one-shot mode: count holds at period, tc_pulse<=1, done<=1, go to DONE.
  - DONE: count holds, done=1. start goes to LOAD (done clears in LOAD). stop goes to IDLE.
- Strobe handling:
  - stop in any state goes to IDLE next cycle: count<=0, prescaler<=0, done<=0. No tc_pulse is issued.
  - start and stop in the same cycle: stop wins.
  - start while in RUN or LOAD is ignored (no restart).
- Timing and latency:
  - Start latency: start sampled at edge E0 → LOAD after E0 → RUN after E1 with count=0.
  - With prescale=0, count first becomes 1 after E2.
  - Periodic: tc_pulse period is (period+1)*(prescale+1) cycles. tc_pulse is high in the cycle where count reads 0 after a wrap.
- Arithmetic: count increments modulo 2^CNT_W. The terminal compare is equality, so count never exceeds period.
- Boundary cases:
  - period=0: count stays 0; a tc occurs on every tick.
  - period=8'hFF: count wraps from FF to 00 exactly at tc.
  - tc_pulse is never asserted on two consecutive cycles unless period=0 and prescale=0. In that case it is continuous in periodic mode.
- Reset mid-RUN aborts immediately. No pulse is produced on reset release.

Optional Feature:
- Macro: TIMER_CTRL_IRQ_EN.
- When defined, add two ports:
  - irq_clr, input, 1: clears the irq latch.
  - irq, output, 1, reset 0: sticky level. Set by each tc_pulse, cleared by irq_clr.
- If set and clear occur in the same cycle, set wins.
- When undefined: no irq/irq_clr ports and no latch logic; behaviour is otherwise identical.

Decomposition:
- Shared package timer_pkg holds:
  - State encoding constants: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3.
  - Mode constants: MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
  - Config reset defaults.
- One sub-module, timer_cnt_core: CNT_W counter with sync clear, enable (tick) and terminal-compare output.
  - Register-level only; the FSM and prescaler live in timer_ctrl.

Test Plan:
- Reset during RUN (count=5) → count=0, busy=0, done=0, tc_pulse=0 asynchronously. After release, stays IDLE with no activity.
- Periodic: period=3, prescale=0, start → busy after 1 cycle; count 0,1,2,3,0,1…; tc_pulse every 4 cycles aligned with count=0; done stays 0.
- One-shot: period=2, prescale=1 → count advances every 2 cycles; after 6 RUN cycles tc_pulse for one cycle; state DONE, done=1, count holds 2. A restart clears done.
- Stop and start in the same cycle during RUN → IDLE, count=0, no tc_pulse. cfg_we while busy (period=9) is ignored and the next run still uses 3.
- period=0, prescale=0, periodic → tc_pulse continuously high, count=0. period=FF → exactly one tc per 256 ticks, FF→00 wrap.
- With TIMER_CTRL_IRQ_EN: tc sets irq; irq_clr in the same cycle as a tc leaves irq=1; irq_clr alone clears to 0.
